// File: rtl/spm_arbiter_if.sv
// Port bundle between the pipeline/bus requesters, the SPM arbiter and the SPM macro.
interface spm_arbiter_if;
    logic        mem_as_;
    logic        mem_rw;
    logic [29:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_busy;
    logic        if_as_;
    logic [29:0] if_addr;
    logic [31:0] if_rd_data;
    logic        if_rd_valid;
    logic        if_busy;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic        spm_as_;
    logic        spm_rw;
    logic [29:0] spm_addr;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;

    modport slave (
        input  mem_as_, mem_rw, mem_addr, mem_wr_data,
        output mem_rd_data, mem_rd_valid, mem_busy,
        input  if_as_, if_addr,
        output if_rd_data, if_rd_valid, if_busy,
        input  bus_as_, bus_rw, bus_addr, bus_wr_data,
        output bus_rd_data, bus_rdy_,
        output spm_as_, spm_rw, spm_addr, spm_wr_data,
        input  spm_rd_data
    );

    modport master (
        output mem_as_, mem_rw, mem_addr, mem_wr_data,
        input  mem_rd_data, mem_rd_valid, mem_busy,
        output if_as_, if_addr,
        input  if_rd_data, if_rd_valid, if_busy,
        output bus_as_, bus_rw, bus_addr, bus_wr_data,
        input  bus_rd_data, bus_rdy_,
        input  spm_as_, spm_rw, spm_addr, spm_wr_data,
        output spm_rd_data
    );
endinterface

// File: rtl/spm_arbiter.sv
// Single-port SPM arbiter for MEM, IF and an external bus port,
// with one-cycle read return tracking and bus anti-starvation aging.
module spm_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic         clk,
    input logic         reset,
    spm_arbiter_if.slave port
);
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_MEM,
        OWN_IF,
        OWN_BUS
    } owner_t;

    owner_t     rd_owner;
    owner_t     owner_nxt;
    logic [3:0] wait_cnt;
    logic       rdy_q;
    logic       mem_req;
    logic       if_req;
    logic       bus_req;
    logic       starve;
    logic       g_mem;
    logic       g_if;
    logic       g_bus;
    logic       bus_ack;

    // The bus is not a requester in its own ack cycle.
    assign mem_req = !reset && !port.mem_as_;
    assign if_req  = !reset && !port.if_as_;
    assign bus_req = !reset && !port.bus_as_ && rdy_q;
    assign starve  = bus_req && (wait_cnt >= 4'(STARVE_MAX));

    always_comb begin
        g_mem = 1'b0;
        g_if  = 1'b0;
        g_bus = 1'b0;
        if (starve)
            g_bus = 1'b1;
        else if (mem_req)
            g_mem = 1'b1;
        else if (if_req)
            g_if = 1'b1;
        else if (bus_req)
            g_bus = 1'b1;
    end

    always_comb begin
        port.spm_as_     = 1'b1;
        port.spm_rw      = 1'b1;
        port.spm_addr    = '0;
        port.spm_wr_data = '0;
        owner_nxt        = OWN_NONE;
        if (g_mem) begin
            port.spm_as_     = 1'b0;
            port.spm_rw      = port.mem_rw;
            port.spm_addr    = port.mem_addr;
            port.spm_wr_data = port.mem_wr_data;
            if (port.mem_rw)
                owner_nxt = OWN_MEM;
        end else if (g_if) begin
            port.spm_as_  = 1'b0;
            port.spm_addr = port.if_addr;
            owner_nxt     = OWN_IF;
        end else if (g_bus) begin
            port.spm_as_     = 1'b0;
            port.spm_rw      = port.bus_rw;
            port.spm_addr    = port.bus_addr;
            port.spm_wr_data = port.bus_wr_data;
            if (port.bus_rw)
                owner_nxt = OWN_BUS;
        end
    end

    assign port.mem_busy = mem_req && !g_mem;
    assign port.if_busy  = if_req && !g_if;

    // Returns are gated by reset so an in-flight read is dropped.
    assign bus_ack           = !reset && !rdy_q;
    assign port.bus_rdy_     = !bus_ack;
    assign port.mem_rd_valid = !reset && (rd_owner == OWN_MEM);
    assign port.if_rd_valid  = !reset && (rd_owner == OWN_IF);
    assign port.mem_rd_data  = port.spm_rd_data;
    assign port.if_rd_data   = port.spm_rd_data;
    assign port.bus_rd_data  = (bus_ack && rd_owner == OWN_BUS) ?
                               port.spm_rd_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner <= OWN_NONE;
            wait_cnt <= '0;
            rdy_q    <= 1'b1;
        end else begin
            rd_owner <= owner_nxt;
            rdy_q    <= !g_bus;
            if (port.bus_as_ || g_bus)
                wait_cnt <= '0;
            else if (rdy_q && wait_cnt != 4'hF)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end
endmodule
